pattern_scan_engine: RTL and testbench

- Hardware responder for the program-3 pattern-count protocol.
- On reset release, reads the 5-bit pattern from data-memory byte 32 and scans bytes 0..31 as a 256-bit string, with byte 0 as MSB.
- Writes three counts to bytes 33/34/35, then raises done.
- Sits beside the data memory as an alternative master to the core; shares the core's memory port through a top-level mux.

---
 rtl/pattern_scan_engine_pkg.sv | 18 +
 rtl/pattern_scan_engine_if.sv | 26 ++
 rtl/pattern_scan_engine_win_match_cnt.sv | 25 ++
 rtl/pattern_scan_engine.sv | 119 +++++++++++
 tb/tb_pattern_scan_engine.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/pattern_scan_engine_pkg.sv
// Shared types and default constants for the pattern-count responder.
package pat_scan_pkg;

  typedef enum logic [2:0] {
    LOAD_PAT,
    SCAN,
    WR_B,
    WR_O,
    WR_S,
    DONE
  } state_t;

  localparam int DEF_NBYTES   = 32;
  localparam int DEF_PAT_ADDR = 32;
  localparam int DEF_RES_ADDR = 33;
  localparam int CW           = 8;

endpackage

// File: rtl/pattern_scan_engine_if.sv
// Data-memory port shared with the core, plus the completion flag.
interface pattern_scan_engine_if #(
  parameter int AW = 8
);
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic          done;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    output done,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    input  done,
    output mem_rdata
  );
endinterface

// File: rtl/pattern_scan_engine_win_match_cnt.sv
// Counts 5-bit pattern matches at four consecutive bit offsets of a 16-bit word.
module win_match_cnt (
  input  logic [15:0] i_word,
  input  logic [4:0]  i_pat,
  input  logic [1:0]  i_base,
  output logic [2:0]  o_cnt
);

  logic [19:0] w_pad;
  logic [3:0]  w_hit;

  assign w_pad = {4'b0000, i_word};

  for (genvar gi = 0; gi < 4; gi++) begin : g_win
    logic [3:0] w_off;
    logic [4:0] w_win;
    assign w_off = {i_base, 2'b00} + 4'(gi);
    assign w_win = w_pad[w_off +: 5];
    // Windows reaching past bit 15 would compare against padding, so they never match.
    assign w_hit[gi] = (w_off <= 4'd11) && (w_win == i_pat);
  end

  assign o_cnt = 3'(w_hit[0]) + 3'(w_hit[1]) + 3'(w_hit[2]) + 3'(w_hit[3]);

endmodule

// File: rtl/pattern_scan_engine.sv
// Reads a 5-bit pattern, scans a 256-bit string in memory, and writes the
// in-byte, per-byte-hit and full-stream match counts back to memory.
module pattern_scan_engine
  import pat_scan_pkg::*;
#(
  parameter int NBYTES   = DEF_NBYTES,
  parameter int PAT_ADDR = DEF_PAT_ADDR,
  parameter int RES_ADDR = DEF_RES_ADDR,
  parameter int AW       = 8
) (
  input logic                   clk,
  input logic                   reset,
  pattern_scan_engine_if.master bus
);

  state_t        r_state;
  state_t        w_state_next;
  logic [4:0]    r_pat;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_prev;
  logic [CW-1:0] r_ctb;
  logic [CW-1:0] r_cto;
  logic [CW-1:0] r_cts;
  logic          r_done;

  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [7:0]    w_wdata;
  logic [2:0]    w_m;
  logic [2:0]    w_c;
  logic [2:0]    w_c_eff;

  win_match_cnt u_in_byte (
    .i_word ({r_prev, bus.mem_rdata}),
    .i_pat  (r_pat),
    .i_base (2'd0),
    .o_cnt  (w_m)
  );

  win_match_cnt u_cross (
    .i_word ({r_prev, bus.mem_rdata}),
    .i_pat  (r_pat),
    .i_base (2'd1),
    .o_cnt  (w_c)
  );

  // The first byte has no predecessor, so it contributes no crossing windows.
  assign w_c_eff = (r_idx != '0) ? w_c : 3'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD_PAT;
      r_pat   <= '0;
      r_idx   <= '0;
      r_prev  <= '0;
      r_ctb   <= '0;
      r_cto   <= '0;
      r_cts   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        LOAD_PAT: begin
          r_pat <= bus.mem_rdata[7:3];
          r_idx <= '0;
        end
        SCAN: begin
          r_ctb  <= r_ctb + CW'(w_m);
          r_cto  <= r_cto + CW'(w_m != 3'd0);
          r_cts  <= r_cts + CW'(w_m) + CW'(w_c_eff);
          r_prev <= bus.mem_rdata;
          r_idx  <= r_idx + 1'b1;
        end
        WR_S:    r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr       = AW'(PAT_ADDR);
    w_we         = 1'b0;
    w_wdata      = 8'h00;
    case (r_state)
      LOAD_PAT: w_state_next = SCAN;
      SCAN: begin
        w_addr = r_idx;
        if (r_idx == AW'(NBYTES - 1)) w_state_next = WR_B;
      end
      WR_B: begin
        w_addr       = AW'(RES_ADDR);
        w_we         = 1'b1;
        w_wdata      = r_ctb;
        w_state_next = WR_O;
      end
      WR_O: begin
        w_addr       = AW'(RES_ADDR + 1);
        w_we         = 1'b1;
        w_wdata      = r_cto;
        w_state_next = WR_S;
      end
      WR_S: begin
        w_addr       = AW'(RES_ADDR + 2);
        w_we         = 1'b1;
        w_wdata      = r_cts;
        w_state_next = DONE;
      end
      default: ;
    endcase
  end

  // A reset arriving during a write cycle suppresses that write.
  assign bus.mem_we    = w_we & ~reset;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Bench for pattern_scan_engine: directed and random strings against a bit-level model.
module tb_pattern_scan_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  logic [7:0]  mem [256];
  logic [7:0]  wr_a [$];
  logic [7:0]  wr_d [$];

  pattern_scan_engine_if #(.AW(8)) bus ();

  pattern_scan_engine #(
    .NBYTES   (32),
    .PAT_ADDR (32),
    .RES_ADDR (33),
    .AW       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_a.push_back(bus.mem_addr);
      wr_d.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts computed on the string as a flat MSB-first bit sequence.
  task automatic model(input logic [4:0] p, output int ctb, output int cto, output int cts);
    bit s [256];
    bit byte_hit [32];
    bit hit;
    ctb = 0; cto = 0; cts = 0;
    for (int k = 0; k < 32; k++) begin
      byte_hit[k] = 1'b0;
      for (int t = 0; t < 8; t++) s[8*k+t] = mem[k][7-t];
    end
    for (int j = 0; j <= 251; j++) begin
      hit = 1'b1;
      for (int t = 0; t < 5; t++) if (s[j+t] != p[4-t]) hit = 1'b0;
      if (hit) begin
        cts++;
        if ((j % 8) <= 3) begin
          ctb++;
          byte_hit[j/8] = 1'b1;
        end
      end
    end
    for (int k = 0; k < 32; k++) if (byte_hit[k]) cto++;
  endtask

  task automatic fill(input logic [7:0] v, input logic [4:0] p);
    for (int k = 0; k < 256; k++) mem[k] = v;
    mem[32] = {p, 3'($urandom_range(0, 7))};
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check({tag, "/done_cycle"}, seen ? cyc : -1, exp_cyc);
  endtask

  task automatic check_writes(input string tag, input int e_b, input int e_o, input int e_s);
    int exp_d [3];
    exp_d[0] = e_b; exp_d[1] = e_o; exp_d[2] = e_s;
    repeat (4) @(negedge clk);
    check({tag, "/done_held"}, bus.done, 1);
    check({tag, "/write_count"}, wr_a.size(), 3);
    if (wr_a.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check({tag, $sformatf("/wr%0d_addr", i)}, wr_a[i], 33 + i);
        check({tag, $sformatf("/wr%0d_data", i)}, wr_d[i], exp_d[i]);
      end
    end
  endtask

  task automatic run_case(input string tag, input int e_b, input int e_o, input int e_s);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "/rst_addr"}, bus.mem_addr, 32);
    check({tag, "/rst_we"}, bus.mem_we, 0);
    check({tag, "/rst_wdata"}, bus.mem_wdata, 0);
    check({tag, "/rst_done"}, bus.done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wr_a.delete();
    wr_d.delete();
    wait_done(tag, 36);
    check_writes(tag, e_b, e_o, e_s);
    $display("case %s pat=%b ctb=%0d cto=%0d cts=%0d", tag, mem[32][7:3], e_b, e_o, e_s);
  endtask

  initial begin
    int mb, mo, ms;
    logic [4:0] p;

    fill(8'hFF, 5'b11111);
    run_case("all_ones", 128, 32, 252);

    fill(8'h00, 5'b11111);
    run_case("all_zero", 0, 0, 0);

    fill(8'h55, 5'b10101);
    run_case("alt_55", 64, 32, 126);

    fill(8'h00, 5'b11111);
    mem[0] = 8'h07;
    mem[1] = 8'hC0;
    run_case("crossing", 0, 0, 1);

    for (int n = 0; n < 1000; n++) begin
      p = 5'($urandom);
      for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
      mem[32] = {p, 3'($urandom)};
      model(p, mb, mo, ms);
      run_case($sformatf("rand%0d", n), mb, mo, ms);
    end

    // Abort a run at cycle 20, then let the restarted run finish.
    p = 5'($urandom);
    for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
    mem[32] = {p, 3'b000};
    model(p, mb, mo, ms);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wr_a.delete();
    wr_d.delete();
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort/done_low", bus.done, 0);
    check("abort/we_low", bus.mem_we, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort/no_writes", wr_a.size(), 0);
    wait_done("abort", 36);
    check_writes("abort", mb, mo, ms);
    $display("case abort pat=%b ctb=%0d cto=%0d cts=%0d", p, mb, mo, ms);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
